// File: rtl/result_display_pkg.sv
// Shared types and 7-segment encodings for the result display stage.
package result_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHOW
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/result_display_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, done pulses after
// the last shift with bcd holding the final value.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i+:4] >= 4'd5) adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
    end
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      bcd_d  = {adj[4*DIGITS-2:0], sh_q[WIDTH-1]};
      sh_d   = sh_q << 1;
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/result_display.sv
// Converts a signed-magnitude result to BCD and cycles its symbols
// on one 7-segment digit with a dwell/gap cadence.
module result_display
  import result_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int DWELL  = 10_000_000,
  parameter int GAP    = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             neg_i,
  output logic             ready_o,
  output logic [6:0]       segments_o,
  output logic             dp_o,
  output logic             busy_o
);

  localparam int M1   = (DWELL > GAP) ? DWELL : GAP;
  localparam int MAXC = (M1 > WIDTH) ? M1 : WIDTH;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int NSYM = DIGITS + 1;
  localparam int LW   = $clog2(NSYM + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LW-1:0]      idx_q, idx_d, len_q, len_d, len_c, idx_n;
  logic [NSYM*7-1:0]  sym_q, sym_d, sym_c;
  logic               gap_q, gap_d, run_q, run_d, neg_q, neg_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               accept, conv_done;
  logic [4*DIGITS-1:0] bcd;

  assign accept = valid_i && ready_o;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (data_i),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Symbols are shifted in from the bottom, so the first one to show
  // sits at index len-1 and the last (dp) symbol at index 0.
  always_comb begin
    logic started;
    started = 1'b0;
    sym_c   = '0;
    len_c   = '0;
    if (neg_q) begin
      sym_c = {sym_c[NSYM*7-8:0], SEG_MINUS};
      len_c = len_c + LW'(1);
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd[4*i+:4] != 4'd0 || started || i == 0) begin
        started = 1'b1;
        sym_c   = {sym_c[NSYM*7-8:0], digit_to_seg(bcd[4*i+:4])};
        len_c   = len_c + LW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    sym_d   = sym_q;
    gap_d   = gap_q;
    run_d   = run_q;
    neg_d   = neg_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    idx_n   = (idx_q == '0) ? len_q - LW'(1) : idx_q - LW'(1);
    if (accept) begin
      state_d = CONVERT;
      cnt_d   = CW'(WIDTH - 1);
      neg_d   = neg_i;
      run_d   = 1'b0;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        CONVERT: begin
          if (cnt_q == '0) state_d = SHOW;
          else             cnt_d   = cnt_q - CW'(1);
        end
        SHOW: begin
          if (conv_done) begin
            sym_d = sym_c;
            len_d = len_c;
            idx_d = len_c - LW'(1);
            seg_d = sym_c[(int'(len_c) - 1)*7+:7];
            dp_d  = (len_c == LW'(1));
            cnt_d = CW'(DWELL - 1);
            gap_d = 1'b0;
            run_d = 1'b1;
          end else if (run_q) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
            end else if (!gap_q) begin
              gap_d = 1'b1;
              cnt_d = CW'(GAP - 1);
              seg_d = SEG_BLANK;
              dp_d  = 1'b0;
            end else begin
              gap_d = 1'b0;
              cnt_d = CW'(DWELL - 1);
              idx_d = idx_n;
              seg_d = sym_q[int'(idx_n)*7+:7];
              dp_d  = (idx_n == '0);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      sym_q   <= '0;
      gap_q   <= 1'b0;
      run_q   <= 1'b0;
      neg_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sym_q   <= sym_d;
      gap_q   <= gap_d;
      run_q   <= run_d;
      neg_q   <= neg_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign ready_o    = (state_q != CONVERT);
  assign busy_o     = (state_q == CONVERT);
  assign segments_o = seg_q;
  assign dp_o       = dp_q;

endmodule

// File: doc/result_display.md
# result_display

Downstream display stage of the calculator. Takes a signed-magnitude result from the calculator core, converts it to BCD with a sequential double-dabble, and shows it one symbol at a time on the single 7-segment digit. Each symbol is held for a dwell period, followed by a blank gap, and the sequence repeats until a new result arrives. It drives the 7-segment outputs (uo_out[6:0]) and the decimal point (uo_out[7]) of the top level.

## Interface
Parameters:
- WIDTH, 8: magnitude width of the incoming result.
- DIGITS, 3: BCD digits; must satisfy 10^DIGITS > 2^WIDTH.
- DWELL, 10_000_000: clock cycles each symbol is lit, ≥1.
- GAP, 2_000_000: blank clock cycles after each symbol, ≥1.

Ports:
- clk, input, 1: single clock; all state on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- valid_i, input, 1: new result present.
- data_i, input, WIDTH: result magnitude, unsigned.
- neg_i, input, 1: result is negative; sampled with data_i.
- ready_o, input-accept, output, 1: block can take a result.
- segments_o, output, 7: segments {g,f,e,d,c,b,a}, active-high, registered.
- dp_o, output, 1: lit during the last symbol of each sequence, registered.
- busy_o, output, 1: high in CONVERT.

## Operation
- **Handshake:** a result is accepted on a rising edge with valid_i && ready_o. data_i and neg_i are captured on that edge.
- **ready_o:** high in IDLE and SHOW, low in CONVERT. A new result accepted in SHOW preempts the display immediately.
- **States:**
  - IDLE: segments blank, dp_o=0. Accept moves to CONVERT.
  - CONVERT: one double-dabble iteration per cycle, WIDTH cycles. Before each shift, add 3 to any BCD nibble ≥5. Then load the symbol list and go to SHOW.
  - SHOW: alternates symbol phase (DWELL cycles) and gap phase (GAP cycles). After the gap of the last symbol, wrap to the first symbol. Stays in SHOW until an accept, which moves to CONVERT.
- **Symbol list:**
  - Optional minus (0x40) when neg_i=1, including for magnitude 0.
  - Then the BCD digits most-significant first, with leading zeros suppressed. The least-significant digit is always shown.
  - Length is 1..DIGITS+1.
- **Encodings:** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, minus=40, blank=00.
- **Gap and dp:** segments_o=00 during every gap. dp_o=1 only during the symbol phase of the last symbol.
- **Counters:** the dwell/gap counter is wide enough for max(DWELL, GAP). It reloads on every phase change and on every accept.

## Timing
- **Reset:** asynchronous. State=IDLE, segments_o=00, dp_o=0, ready_o=1, busy_o=0, all counters and BCD cleared.
- **Reset mid-operation:** reset in CONVERT or SHOW returns to IDLE at once. The pending value is discarded.
- **Accept edge N:**
  - busy_o=1 and segments_o=00 from edge N.
  - busy_o falls at edge N+WIDTH.
  - The first symbol is visible after edge N+WIDTH+1.
  - It is held for exactly DWELL cycles, then GAP blank cycles, then the next symbol.
- **Preempting accept in SHOW:** blanks the outputs after that same edge. It restarts the full latency.
- **valid_i in CONVERT:** ignored because ready_o=0. The upstream holds the result.
- **Single-symbol list:** repeats symbol/gap with dp_o=1 every symbol phase.

## Structure
- **Package result_display_pkg:**
  - state enum {IDLE, CONVERT, SHOW}.
  - 7-bit segment constants for 0–9, minus and blank.
  - A digit-to-segment function.
- **Sub-module bin2bcd_seq:**
  - Sequential double-dabble, parameters WIDTH and DIGITS.
  - Ports: clk, rst, start, bin[WIDTH-1:0], done, bcd[4*DIGITS-1:0].
  - done pulses one cycle after WIDTH iterations.
- **Top:** holds the handshake, the SHOW sequencer, the symbol index and the dwell/gap counter.

## Test plan
Bench uses DWELL=4, GAP=2, WIDTH=8, DIGITS=3.
- **Three digits:** accept 123, neg 0 -> after 9 edges: 06×4 cycles, 00×2, 5B×4, 00×2, 4F×4 with dp_o=1, 00×2, then repeats from 06.
- **Leading zeros:** accept 7 -> only 07 with dp_o=1. Accept 0 -> only 3F with dp_o=1.
- **Negative and max:** accept 45 with neg_i=1 -> 40, 66, 6D(dp). Accept 255 -> 5B, 6D, 6D(dp). busy_o is high exactly 8 cycles.
- **Handshake:** valid_i held during CONVERT -> ready_o=0, no second capture. A new value 9 accepted mid-SHOW -> blank next cycle, 6F appears 9 edges later.
- **Reset:** assert rst mid-CONVERT and mid-symbol -> segments_o=00, dp_o=0, ready_o=1, busy_o=0 immediately, without waiting for a clock edge. Release, then accept 1 -> 06 after 9 edges.
